// File: rtl/fp_addsub_slot_if.sv
// Slot bus bundle for fp_addsub_slot: select, read/write strobes,
// word address, write data and registered read data.
interface fp_addsub_slot_if #(
    parameter int DATA_W = 32
);
    logic              cs;
    logic              read;
    logic              write;
    logic [4:0]        addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/fp_addsub_slot.sv
// Memory-mapped floating-point add/subtract slot. Software loads OPA/OPB,
// pulses START (optionally with SUB) in CTRL, polls STATUS and reads RESULT.
// The datapath walks ALIGN -> ADD -> NORM -> ROUND, one cycle each, with
// round-to-nearest-even, flush-to-zero of subnormals and exception flags.
module fp_addsub_slot #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_slot_if.slave bus
);
    localparam int FW  = 1 + EXP_W + MAN_W;     // packed float width
    localparam int SW  = MAN_W + 4;             // hidden + fraction + G/R/S
    localparam int EW2 = EXP_W + 2;             // exponent with sign/overflow room
    localparam int LZW = $clog2(SW + 1);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [FW-1:0]    QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] A_OPA    = 3'd0;
    localparam logic [2:0] A_OPB    = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_RESULT = 3'd4;

    typedef enum logic [2:0] {ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND} state_t;

    state_t state_q, state_d;

    // Software-visible registers
    logic [FW-1:0]     opa_q, opb_q, result_q;
    logic              sub_q, run_sub_q;
    logic              done_q, ovf_q, unf_q, nan_q, inexact_q, zero_q;
    logic [DATA_W-1:0] rd_data_q, read_mux;

    // Working registers shared by the pipeline steps (one operation in flight)
    logic              w_sign, w_eff_sub, w_special, w_nan, w_zero;
    logic [EW2-1:0]    w_exp;
    logic [SW-1:0]     w_sig_x, w_sig_y, w_sig;
    logic [SW:0]       w_sum;
    logic [FW-1:0]     w_spec_val;

    // Bus decode
    logic [2:0] reg_addr;
    logic       wr_en, rd_en, busy, cfg_wr, start;
    logic       unused_bus;

    assign reg_addr   = bus.addr[2:0];
    assign wr_en      = bus.cs & bus.write;
    assign rd_en      = bus.cs & bus.read;
    assign busy       = (state_q != ST_IDLE);
    assign cfg_wr     = wr_en & ~busy;
    assign start      = cfg_wr && (reg_addr == A_CTRL) && bus.wr_data[0];
    assign unused_bus = &{1'b0, bus.addr, bus.wr_data};

    function automatic logic [LZW-1:0] count_lz(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = LZW'(SW - 1 - i);
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- FSM
    // State register: reset aborts any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: fixed one-cycle walk through the datapath steps.
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- ALIGN
    logic                sign_a, sign_b, sx, sy, nan_a, nan_b, inf_a, inf_b, a_ge_b;
    logic [EXP_W-1:0]    exp_a, exp_b, ex, ey, diff;
    logic [MAN_W-1:0]    frac_a, frac_b;
    logic [SW-1:0]       sig_a, sig_b, sig_x, sig_y, sig_y_al, lost_mask;
    logic                al_special, al_nan;
    logic [FW-1:0]       al_spec_val;

    // Unpack, flush subnormals, order by magnitude and align the smaller operand.
    always_comb begin
        sign_a = opa_q[FW-1];
        sign_b = opb_q[FW-1] ^ run_sub_q;
        exp_a  = opa_q[FW-2:MAN_W];
        exp_b  = opb_q[FW-2:MAN_W];
        frac_a = (exp_a == '0) ? '0 : opa_q[MAN_W-1:0];
        frac_b = (exp_b == '0) ? '0 : opb_q[MAN_W-1:0];
        nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
        nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
        inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
        inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);
        sig_a  = (exp_a == '0) ? '0 : {1'b1, frac_a, 3'b000};
        sig_b  = (exp_b == '0) ? '0 : {1'b1, frac_b, 3'b000};

        a_ge_b = {exp_a, frac_a} >= {exp_b, frac_b};
        if (a_ge_b) begin
            sx = sign_a; ex = exp_a; sig_x = sig_a;
            sy = sign_b; ey = exp_b; sig_y = sig_b;
        end else begin
            sx = sign_b; ex = exp_b; sig_x = sig_b;
            sy = sign_a; ey = exp_a; sig_y = sig_a;
        end

        diff      = ex - ey;
        lost_mask = '0;
        if (32'(diff) >= 32'(MAN_W + 3)) begin
            sig_y_al = {{(SW-1){1'b0}}, |sig_y};
        end else begin
            lost_mask = (SW'(1) << diff) - SW'(1);
            sig_y_al  = (sig_y >> diff) | {{(SW-1){1'b0}}, |(sig_y & lost_mask)};
        end

        al_special = nan_a | nan_b | inf_a | inf_b;
        al_nan     = nan_a | nan_b | (inf_a & inf_b & (sign_a != sign_b));
        if (al_nan)     al_spec_val = QNAN;
        else if (inf_a) al_spec_val = {sign_a, EXP_MAX, {MAN_W{1'b0}}};
        else            al_spec_val = {sign_b, EXP_MAX, {MAN_W{1'b0}}};
    end

    // ---------------------------------------------------------------- ADD
    logic [SW:0] sum_d;
    assign sum_d = w_eff_sub ? ({1'b0, w_sig_x} - {1'b0, w_sig_y})
                             : ({1'b0, w_sig_x} + {1'b0, w_sig_y});

    // --------------------------------------------------------------- NORM
    logic [LZW-1:0] lz;
    logic [SW-1:0]  n_sig;
    logic [EW2-1:0] n_exp;
    logic           n_zero;

    // Renormalise: carry shifts right, otherwise leading zeros shift left.
    always_comb begin
        lz     = count_lz(w_sum[SW-1:0]);
        n_sig  = '0;
        n_exp  = '0;
        n_zero = 1'b0;
        if (w_sum[SW]) begin
            n_sig = {w_sum[SW:2], w_sum[1] | w_sum[0]};
            n_exp = w_exp + EW2'(1);
        end else if (w_sum == '0) begin
            n_zero = 1'b1;
        end else begin
            n_sig = w_sum[SW-1:0] << lz;
            n_exp = w_exp - EW2'(lz);
        end
    end

    // -------------------------------------------------------------- ROUND
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] r_frac;
    logic [EW2-1:0]   r_exp;
    logic             rnd_up, lost;
    logic [FW-1:0]    fin_result;
    logic             fin_ovf, fin_unf, fin_nan, fin_inexact, fin_zero;

    // Round to nearest even, then classify the final exponent.
    always_comb begin
        mant   = w_sig[SW-1:3];
        lost   = |w_sig[2:0];
        rnd_up = w_sig[2] & (w_sig[1] | w_sig[0] | mant[0]);
        mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_r[MAN_W+1]) begin
            r_exp  = w_exp + EW2'(1);
            r_frac = mant_r[MAN_W:1];
        end else begin
            r_exp  = w_exp;
            r_frac = mant_r[MAN_W-1:0];
        end

        fin_result  = {w_sign, r_exp[EXP_W-1:0], r_frac};
        fin_ovf     = 1'b0;
        fin_unf     = 1'b0;
        fin_nan     = 1'b0;
        fin_inexact = 1'b0;
        fin_zero    = 1'b0;
        if (w_special) begin
            fin_result = w_spec_val;
            fin_nan    = w_nan;
        end else if (w_zero) begin
            fin_result = {w_sign, {(FW-1){1'b0}}};
            fin_zero   = 1'b1;
        end else if (!r_exp[EW2-1] && (r_exp >= {2'b00, EXP_MAX})) begin
            fin_result  = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
            fin_ovf     = 1'b1;
            fin_inexact = 1'b1;
        end else if (r_exp[EW2-1] || (r_exp == '0)) begin
            // A nonzero value below the smallest normal is lost entirely.
            fin_result  = {w_sign, {(FW-1){1'b0}}};
            fin_unf     = 1'b1;
            fin_inexact = 1'b1;
        end else begin
            fin_inexact = lost;
        end
    end

    // Datapath working registers, loaded by whichever step is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_sign     <= 1'b0;
            w_eff_sub  <= 1'b0;
            w_special  <= 1'b0;
            w_nan      <= 1'b0;
            w_zero     <= 1'b0;
            w_exp      <= '0;
            w_sig_x    <= '0;
            w_sig_y    <= '0;
            w_sig      <= '0;
            w_sum      <= '0;
            w_spec_val <= '0;
        end else begin
            case (state_q)
                ST_ALIGN: begin
                    w_sign     <= sx;
                    w_eff_sub  <= sx ^ sy;
                    w_exp      <= {2'b00, ex};
                    w_sig_x    <= sig_x;
                    w_sig_y    <= sig_y_al;
                    w_special  <= al_special;
                    w_nan      <= al_nan;
                    w_spec_val <= al_spec_val;
                end
                ST_ADD: w_sum <= sum_d;
                ST_NORM: begin
                    w_sig  <= n_sig;
                    w_exp  <= n_exp;
                    w_zero <= n_zero;
                    // Exact cancellation is +0; like-signed zeros keep their sign.
                    if (n_zero) w_sign <= w_sign & ~w_eff_sub;
                end
                default: ;
            endcase
        end
    end

    // Software registers: config writes when idle, result/flags at ROUND exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            sub_q     <= 1'b0;
            run_sub_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            nan_q     <= 1'b0;
            inexact_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (reg_addr)
                    A_OPA:   opa_q <= bus.wr_data[FW-1:0];
                    A_OPB:   opb_q <= bus.wr_data[FW-1:0];
                    A_CTRL:  sub_q <= bus.wr_data[1];
                    default: ;
                endcase
            end
            if (start) begin
                run_sub_q <= bus.wr_data[1];
                done_q    <= 1'b0;
                ovf_q     <= 1'b0;
                unf_q     <= 1'b0;
                nan_q     <= 1'b0;
                inexact_q <= 1'b0;
                zero_q    <= 1'b0;
            end
            if (state_q == ST_ROUND) begin
                result_q  <= fin_result;
                done_q    <= 1'b1;
                ovf_q     <= fin_ovf;
                unf_q     <= fin_unf;
                nan_q     <= fin_nan;
                inexact_q <= fin_inexact;
                zero_q    <= fin_zero;
            end
        end
    end

    // Read multiplexer; unused upper bits read as zero.
    always_comb begin
        read_mux = '0;
        case (reg_addr)
            A_OPA:    read_mux = DATA_W'(opa_q);
            A_OPB:    read_mux = DATA_W'(opb_q);
            A_CTRL:   read_mux = DATA_W'({sub_q, 1'b0});
            A_STATUS: read_mux = DATA_W'({zero_q, inexact_q, nan_q, unf_q, ovf_q, done_q, busy});
            A_RESULT: read_mux = DATA_W'(result_q);
            default:  read_mux = '0;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data_q <= '0;
        else if (rd_en) rd_data_q <= read_mux;
    end

    assign bus.rd_data = rd_data_q;

endmodule

// File: doc/fp_addsub_slot.md
Name: fp_addsub_slot

Overview:
Memory-mapped slot peripheral wrapping a parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit. Software writes operands A and B, then starts an operation through a control register. It polls a status register for busy/done and exception flags, then reads the result. The block replaces the fixed-function 32-bit adder slot and adds subtract mode, a start/done handshake, exception flags and generic formats.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored fraction width (hidden bit excluded).
DATA_W, 32, slot bus width; must satisfy 1+EXP_W+MAN_W <= DATA_W. Operands and result are right-justified; upper bits read 0.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
cs  in  1  slot select.
read  in  1  read strobe, qualified by cs.
write  in  1  write strobe, qualified by cs.
addr  in  5  word address; only addr[2:0] decoded, addr[4:3] ignored.
wr_data  in  DATA_W  write data.
rd_data  out  DATA_W  registered read data.

Behaviour:
- Register map (addr[2:0]):
  - 0 OPA (R/W).
  - 1 OPB (R/W).
  - 2 CTRL: bit0 START (write-1 pulse, reads 0), bit1 SUB (R/W).
  - 3 STATUS (RO): bit0 BUSY, bit1 DONE, bit2 OVF, bit3 UNF, bit4 NAN, bit5 INEXACT, bit6 ZERO.
  - 4 RESULT (RO).
  - 5-7: reads 0, writes ignored.
- Reads: rd_data updates on the clock edge where cs&read is high and holds until the next read. Reset value 0. No combinational read path.
- Writes take effect on the edge where cs&write is high. Writes to OPA, OPB or CTRL while BUSY=1 are ignored entirely.
- Reset: OPA, OPB, SUB, RESULT, STATUS, rd_data all 0. FSM goes to IDLE. Reset mid-operation aborts the operation with no result and no flags.
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - START accepted in IDLE at edge N: BUSY=1 and DONE=0 from edge N, all flags cleared.
  - Each state takes exactly 1 cycle. At edge N+4 (ROUND exit), RESULT, flags and DONE=1 are written and BUSY=0.
  - Fixed latency: 4 cycles from start to DONE.
- SUB=1 computes A-B by inverting B's sign before ALIGN. SUB is sampled at start.
- ALIGN: unpack; subnormal inputs flush to signed zero. Swap so |X|>=|Y|; right-shift Y's significand by the exponent difference, retaining guard, round and sticky bits. Shifts >= MAN_W+3 collapse to sticky.
- ADD: same effective sign adds, else subtracts (always non-negative). Carry-out is handled in NORM.
- NORM: on carry, shift right 1 and increment exponent. Otherwise, use a leading-zero count to shift left and decrement exponent.
- ROUND: round to nearest, ties to even. A mantissa carry after rounding increments the exponent.
- Special cases, with result and flags:
  - NaN operand, or inf + (-inf): canonical quiet NaN (exp all-ones, fraction MSB=1, sign 0). NAN=1.
  - Inf operand otherwise: that inf.
  - Exponent overflow: signed inf. OVF=1, INEXACT=1.
  - Result below the minimum normal: signed zero. UNF=1, plus INEXACT if any nonzero bits are lost.
  - Exact cancellation: +0. ZERO=1.
  - (-0)+(-0) gives -0.
- DONE stays set until the next accepted START or reset; reading RESULT does not clear it.
- A simultaneous START write and read of STATUS returns the pre-edge STATUS value.

Test Plan:
- Reset, then read every address -> all read 0x00000000; STATUS=0.
- OPA=0x3F800000, OPB=0x40000000, SUB=0, START -> BUSY for exactly 4 cycles, then DONE=1. RESULT=0x40400000, flags 0.
- OPA=OPB=0x3F800000, SUB=1 -> RESULT=0x00000000, STATUS=0x42 (DONE, ZERO).
- OPA=OPB=0x7F7FFFFF, add -> RESULT=0x7F800000, OVF=1, INEXACT=1. Then OPA=0x7F800000, OPB=0xFF800000 -> RESULT=0x7FC00000, NAN=1.
- Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even, INEXACT=1). 0x3F800000+0x33800001 -> 0x3F800001 (INEXACT=1).
- Robustness:
  - Write OPA while BUSY -> ignored; RESULT matches the original operands.
  - START while BUSY -> ignored.
  - Assert reset mid-operation (in NORM) -> STATUS=0, RESULT=0, FSM IDLE, with no late DONE.
